// File: rtl/vga_tile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_tile_pkg : tile geometry, slot and clear-FSM encodings for the scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package vga_tile_pkg;
  localparam int TILE_SHIFT   = 3;
  localparam int H_TILES      = 80;
  localparam int V_TILES      = 60;
  localparam int TILE_COUNT   = H_TILES * V_TILES;
  localparam int COLOUR_WIDTH = 12;
  localparam int ADDR_WIDTH   = 13;

  localparam logic [1:0] SLOT_READ = 2'd0;
  localparam logic [1:0] SLOT_W1   = 2'd1;
  localparam logic [1:0] SLOT_W2   = 2'd2;
  localparam logic [1:0] SLOT_W3   = 2'd3;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;
endpackage
`default_nettype wire

// File: rtl/tile_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tile_ram : single-port synchronous tile RAM, one-cycle read latency
// Rev 1.0
// ---------------------------------------------------------------------------
module tile_ram #(
  parameter int DEPTH      = vga_tile_pkg::TILE_COUNT,
  parameter int DATA_WIDTH = vga_tile_pkg::COLOUR_WIDTH,
  parameter int ADDR_WIDTH = vga_tile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/vga_tile_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_tile_scheduler : tile RAM owner; pixel reads in slot 0, round-robin
//                      game-writer / screen-clear writes in slots 1..3
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_tile_scheduler #(
  parameter int TILE_SHIFT   = vga_tile_pkg::TILE_SHIFT,
  parameter int H_TILES      = vga_tile_pkg::H_TILES,
  parameter int V_TILES      = vga_tile_pkg::V_TILES,
  parameter int COLOUR_WIDTH = vga_tile_pkg::COLOUR_WIDTH,
  parameter int ADDR_WIDTH   = vga_tile_pkg::ADDR_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [9:0]              ADDRH,
  input  logic [8:0]              ADDRV,
  output logic [COLOUR_WIDTH-1:0] COLOUR_IN,
  input  logic                    WR_REQ,
  input  logic [ADDR_WIDTH-1:0]   WR_ADDR,
  input  logic [COLOUR_WIDTH-1:0] WR_DATA,
  output logic                    WR_ACK,
  input  logic                    CLEAR_START,
  input  logic [COLOUR_WIDTH-1:0] CLEAR_COLOUR,
  output logic                    CLEAR_BUSY,
  output logic                    CLEAR_DONE
);
  import vga_tile_pkg::*;

  localparam int                    TILES      = H_TILES * V_TILES;
  localparam logic [ADDR_WIDTH-1:0] TILE_LIMIT = ADDR_WIDTH'(TILES);
  localparam logic [ADDR_WIDTH-1:0] LAST_TILE  = ADDR_WIDTH'(TILES - 1);

  logic [1:0]              r_phase;
  logic [COLOUR_WIDTH-1:0] r_colour;
  logic                    r_wr_ack;
  logic                    r_prio_game;
  clr_state_e              r_clr_state;
  clr_state_e              w_clr_next;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;
  logic [COLOUR_WIDTH-1:0] r_clr_colour;

  logic [ADDR_WIDTH-1:0]   w_row;
  logic [ADDR_WIDTH-1:0]   w_col;
  logic [ADDR_WIDTH-1:0]   w_row_base;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;
  logic                    w_write_slot;
  logic                    w_game_elig;
  logic                    w_clr_elig;
  logic                    w_grant_game;
  logic                    w_grant_clr;
  logic                    w_ram_we;
  logic [ADDR_WIDTH-1:0]   w_ram_addr;
  logic [COLOUR_WIDTH-1:0] w_ram_wdata;
  logic [COLOUR_WIDTH-1:0] w_ram_rdata;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_phase <= SLOT_READ;
    end else begin
      r_phase <= r_phase + 2'd1;
    end
  end

  assign w_row = ADDR_WIDTH'(ADDRV >> TILE_SHIFT);
  assign w_col = ADDR_WIDTH'(ADDRH >> TILE_SHIFT);

  // 80 = 64 + 16, so the row multiply is two shifts and an add.
  generate
    if (H_TILES == 80) begin : g_row_x80
      assign w_row_base = (w_row << 6) + (w_row << 4);
    end else begin : g_row_mul
      assign w_row_base = ADDR_WIDTH'(w_row * H_TILES);
    end
  endgenerate

  assign w_rd_addr    = w_row_base + w_col;
  assign w_write_slot = (r_phase == SLOT_W1) || (r_phase == SLOT_W2) || (r_phase == SLOT_W3);
  // The ACK cycle still shows WR_REQ high; masking it stops a second commit.
  assign w_game_elig  = WR_REQ && !r_wr_ack;
  assign w_clr_elig   = (r_clr_state == CLR_SWEEP);

  always_comb begin
    w_grant_game = 1'b0;
    w_grant_clr  = 1'b0;
    if (w_write_slot && !RESET) begin
      if (w_game_elig && w_clr_elig) begin
        w_grant_game = r_prio_game;
        w_grant_clr  = !r_prio_game;
      end else begin
        w_grant_game = w_game_elig;
        w_grant_clr  = w_clr_elig;
      end
    end
  end

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = w_rd_addr;
    w_ram_wdata = r_clr_colour;
    if (w_grant_game) begin
      w_ram_addr  = WR_ADDR;
      w_ram_wdata = WR_DATA;
      w_ram_we    = (WR_ADDR < TILE_LIMIT);
    end else if (w_grant_clr) begin
      w_ram_addr = r_clr_addr;
      w_ram_we   = 1'b1;
    end
  end

  tile_ram #(
    .DEPTH      (TILES),
    .DATA_WIDTH (COLOUR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (CLK),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_colour    <= '0;
      r_wr_ack    <= 1'b0;
      r_prio_game <= 1'b1;
    end else begin
      r_wr_ack <= w_grant_game;
      if (r_phase == SLOT_W1) begin
        r_colour <= w_ram_rdata;
      end
      if (w_grant_game) begin
        r_prio_game <= 1'b0;
      end else if (w_grant_clr) begin
        r_prio_game <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clr_state <= CLR_IDLE;
    end else begin
      r_clr_state <= w_clr_next;
    end
  end

  always_comb begin
    w_clr_next = r_clr_state;
    case (r_clr_state)
      CLR_IDLE:  if (CLEAR_START) w_clr_next = CLR_SWEEP;
      CLR_SWEEP: if (w_grant_clr && (r_clr_addr == LAST_TILE)) w_clr_next = CLR_DONE;
      CLR_DONE:  w_clr_next = CLR_IDLE;
      default:   w_clr_next = CLR_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clr_addr   <= '0;
      r_clr_colour <= '0;
    end else if ((r_clr_state == CLR_IDLE) && CLEAR_START) begin
      r_clr_addr   <= '0;
      r_clr_colour <= CLEAR_COLOUR;
    end else if (w_grant_clr) begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  assign COLOUR_IN  = r_colour;
  assign WR_ACK     = r_wr_ack;
  assign CLEAR_BUSY = (r_clr_state == CLR_SWEEP);
  assign CLEAR_DONE = (r_clr_state == CLR_DONE);
endmodule
`default_nettype wire

// File: tb/tb_vga_tile_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_vga_tile_scheduler : directed stimulus with a queued colour scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_tile_scheduler;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [9:0]  ADDRH;
  logic [8:0]  ADDRV;
  logic [11:0] COLOUR_IN;
  logic        WR_REQ;
  logic [12:0] WR_ADDR;
  logic [11:0] WR_DATA;
  logic        WR_ACK;
  logic        CLEAR_START;
  logic [11:0] CLEAR_COLOUR;
  logic        CLEAR_BUSY;
  logic        CLEAR_DONE;

  always #5 CLK = ~CLK;

  vga_tile_scheduler dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRH        (ADDRH),
    .ADDRV        (ADDRV),
    .COLOUR_IN    (COLOUR_IN),
    .WR_REQ       (WR_REQ),
    .WR_ADDR      (WR_ADDR),
    .WR_DATA      (WR_DATA),
    .WR_ACK       (WR_ACK),
    .CLEAR_START  (CLEAR_START),
    .CLEAR_COLOUR (CLEAR_COLOUR),
    .CLEAR_BUSY   (CLEAR_BUSY),
    .CLEAR_DONE   (CLEAR_DONE)
  );

  typedef struct {
    int unsigned due;
    logic [11:0] exp;
    int          tile;
  } rd_t;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  logic [1:0]  ph       = 2'd0;
  int          n_done   = 0;
  logic        prev_ack = 1'b0;
  logic [11:0] m_mem [4800];
  rd_t         q [$];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    ph  <= RESET ? 2'd0 : ph + 2'd1;
  end

  // Monitor: pops expected colours when due; polices the ACK protocol.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      if (q[0].due == cyc) begin
        checks++;
        if (COLOUR_IN !== q[0].exp) begin
          failures++;
          $display("FAIL colour tile %0d: got %h expected %h", q[0].tile, COLOUR_IN, q[0].exp);
        end
        void'(q.pop_front());
      end else if (q[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL colour tile %0d: missed slot, got %h expected %h", q[0].tile, COLOUR_IN, q[0].exp);
        void'(q.pop_front());
      end
    end
    if (CLEAR_DONE) n_done++;
    if (WR_ACK) begin
      checks++;
      if (ph == 2'd1 || prev_ack) begin
        failures++;
        $display("FAIL ack_timing: got phase %0d prev_ack %0b expected phase!=1 prev_ack 0", ph, prev_ack);
      end
    end
    prev_ack = WR_ACK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_px(input int h, input int v);
    int t;
    t = (v / 8) * 80 + (h / 8);
    @(negedge CLK);
    while (ph != 2'd0) @(negedge CLK);
    ADDRH = h[9:0];
    ADDRV = v[8:0];
    q.push_back('{due: cyc + 2, exp: m_mem[t], tile: t});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("scoreboard_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic game_write(input logic [12:0] a, input logic [11:0] d, input string name);
    int n;
    @(negedge CLK);
    WR_REQ = 1'b1; WR_ADDR = a; WR_DATA = d;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!WR_ACK && n < 16);
    WR_REQ = 1'b0;
    check({name, "_ack"}, WR_ACK, 1);
    @(negedge CLK);
    check({name, "_ack_single"}, WR_ACK, 0);
    if (a < 13'd4800) m_mem[a] = d;
  endtask

  task automatic clear_start(input logic [11:0] c, input string name);
    @(negedge CLK);
    CLEAR_START = 1'b1; CLEAR_COLOUR = c;
    @(negedge CLK);
    CLEAR_START = 1'b0; CLEAR_COLOUR = ~c;
    check({name, "_busy"}, CLEAR_BUSY, 1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!CLEAR_DONE && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_done_in_budget"}, CLEAR_DONE, 1);
    check({name, "_busy_low_at_done"}, CLEAR_BUSY, 0);
  endtask

  task automatic fill_model(input logic [11:0] c);
    for (int i = 0; i < 4800; i++) m_mem[i] = c;
  endtask

  initial begin
    int d0, acks, a, n;
    RESET = 1'b1; ADDRH = '0; ADDRV = '0; WR_REQ = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    CLEAR_START = 1'b0; CLEAR_COLOUR = '0;
    repeat (3) @(negedge CLK);
    check("reset_colour", COLOUR_IN, 0);
    check("reset_ack", WR_ACK, 0);
    check("reset_busy", CLEAR_BUSY, 0);
    check("reset_done", CLEAR_DONE, 0);
    RESET = 1'b0;

    // Full-screen clear and complete readback through the pixel path.
    d0 = n_done;
    clear_start(12'h0F0, "clear1");
    wait_done(6404, "clear1");
    repeat (5) @(negedge CLK);
    check("clear1_done_once", n_done - d0, 1);
    fill_model(12'h0F0);
    for (int t = 0; t < 4800; t++) read_px((t % 80) * 8 + (t % 8), (t / 80) * 8 + (t % 7));
    drain();

    // Pixel readback of game writes.
    game_write(13'd81, 12'hABC, "wr81");
    game_write(13'd4799, 12'h123, "wr4799");
    read_px(8, 8);
    read_px(15, 15);
    read_px(16, 8);
    read_px(639, 479);
    read_px(0, 0);
    drain();

    // Out-of-range write is acknowledged but leaves the RAM alone.
    game_write(13'd4800, 12'hFFF, "wr_oor");
    read_px(0, 0);
    read_px(7, 7);
    drain();

    // Contention: continuous game writes during a sweep.
    d0 = n_done;
    clear_start(12'h00F, "clear2");
    @(negedge CLK);
    a = 0; acks = 0; n = 0;
    WR_REQ = 1'b1; WR_ADDR = 13'd0; WR_DATA = 12'h00F;
    while (!CLEAR_DONE && n < 12900) begin
      @(negedge CLK);
      n++;
      if (WR_ACK) begin
        acks++;
        a = (a + 1) % 4800;
        WR_ADDR = a[12:0];
      end
    end
    WR_REQ = 1'b0;
    check("clear2_done_in_budget", CLEAR_DONE, 1);
    check("contention_fair_share", (acks >= 4790 && acks <= 4810), 1);
    repeat (5) @(negedge CLK);
    check("clear2_done_once", n_done - d0, 1);
    fill_model(12'h00F);
    for (int t = 0; t < 4800; t += 97) read_px((t % 80) * 8 + 3, (t / 80) * 8 + 5);
    read_px(8, 8);
    drain();

    // Re-pulsed CLEAR_START mid-sweep is ignored.
    d0 = n_done;
    clear_start(12'h555, "clear3");
    repeat (132) @(negedge CLK);
    CLEAR_START = 1'b1; CLEAR_COLOUR = 12'hAAA;
    @(negedge CLK);
    CLEAR_START = 1'b0;
    check("clear3_still_busy", CLEAR_BUSY, 1);
    wait_done(6404, "clear3");
    repeat (20) @(negedge CLK);
    check("clear3_done_once", n_done - d0, 1);
    fill_model(12'h555);
    for (int t = 0; t < 4800; t += 7) read_px((t % 80) * 8 + (t % 8), (t / 80) * 8);
    drain();

    // Reset mid-sweep with a game request pending.
    clear_start(12'h333, "clear4");
    repeat (200) @(negedge CLK);
    d0 = n_done;
    RESET = 1'b1; WR_REQ = 1'b1; WR_ADDR = 13'd10; WR_DATA = 12'h777;
    @(negedge CLK);
    check("rst_mid_busy", CLEAR_BUSY, 0);
    check("rst_mid_ack", WR_ACK, 0);
    check("rst_mid_colour", COLOUR_IN, 0);
    @(negedge CLK);
    RESET = 1'b0;
    n = 0;
    while (!WR_ACK && n < 4) begin
      @(negedge CLK);
      n++;
    end
    check("rst_held_req_ack", WR_ACK, 1);
    WR_REQ = 1'b0;
    m_mem[10] = 12'h777;
    read_px(85, 3);
    drain();
    repeat (20) @(negedge CLK);
    check("rst_no_done", n_done - d0, 0);
    check("rst_busy_stays_low", CLEAR_BUSY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
